// File: rtl/mem_pkg.sv
// Shared types for the data-memory access stage.
// Holds the access FSM encoding and the default abort timeout.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_store_fwd.sv
// Store-data bypass from the write-back stage.
// A pending write-back to rs2 overrides the stale register-file value.
module mem_store_fwd (
   input  logic [4:0]  wb_rd,
   input  logic        wb_regs_write,
   input  logic [31:0] wb_data,
   input  logic [4:0]  me_rs2,
   input  logic [31:0] me_regs_data2,
   output logic [31:0] store_data
);

   logic hit;

   assign hit = wb_regs_write && (wb_rd != 5'd0) && (wb_rd == me_rs2);
   assign store_data = hit ? wb_data : me_regs_data2;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: launches data-memory accesses, waits for gnt/rvalid,
// stalls upstream while busy and aborts accesses that hang too long.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] me_alu_o,
   input  logic [31:0] me_regs_data2,
   input  logic [4:0]  me_rs2,
   input  logic [4:0]  me_rd,
   input  logic        me_mem_read,
   input  logic        me_mem_write,
   input  logic        me_mem2reg,
   input  logic        me_regs_write,
   input  logic [4:0]  wb_rd,
   input  logic        wb_regs_write,
   input  logic [31:0] wb_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] mw_data,
   output logic [4:0]  mw_rd,
   output logic        mw_regs_write,
   output logic        mem_stall,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [31:0]   cap_addr, cap_wdata;
   logic          cap_we;
   logic [31:0]   store_data;
   logic          mem_op, aligned, timeout, launch;

   assign mem_op  = me_mem_read | me_mem_write;
   assign aligned = (me_alu_o[1:0] == 2'b00);
   assign timeout = (cnt == CW'(TIMEOUT_CYCLES));

   mem_store_fwd u_fwd (
      .wb_rd         (wb_rd),
      .wb_regs_write (wb_regs_write),
      .wb_data       (wb_data),
      .me_rs2        (me_rs2),
      .me_regs_data2 (me_regs_data2),
      .store_data    (store_data)
   );

   always_comb begin
      state_nxt     = state;
      launch        = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = cap_we;
      dmem_addr     = cap_addr;
      dmem_wdata    = cap_wdata;
      mw_data       = me_alu_o;
      mw_rd         = me_rd;
      mw_regs_write = me_regs_write;
      mem_stall     = 1'b0;
      misalign_o    = 1'b0;
      bus_err_o     = 1'b0;
      unique case (state)
         IDLE: begin
            dmem_we    = me_mem_write;
            dmem_addr  = me_alu_o;
            dmem_wdata = store_data;
            if (mem_op && !aligned) begin
               misalign_o    = 1'b1;
               mw_regs_write = 1'b0;
            end else if (mem_op) begin
               dmem_req = 1'b1;
               launch   = 1'b1;
               if (!dmem_gnt) begin
                  state_nxt     = REQ;
                  mem_stall     = 1'b1;
                  mw_regs_write = 1'b0;
               end else if (!me_mem_write) begin
                  state_nxt     = WAIT;
                  mem_stall     = 1'b1;
                  mw_regs_write = 1'b0;
               end
            end
         end
         REQ: begin
            if (timeout) begin
               bus_err_o     = 1'b1;
               mw_regs_write = 1'b0;
               state_nxt     = IDLE;
            end else begin
               dmem_req = 1'b1;
               if (!dmem_gnt || !cap_we) begin
                  mem_stall     = 1'b1;
                  mw_regs_write = 1'b0;
                  if (dmem_gnt) state_nxt = WAIT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         WAIT: begin
            if (timeout) begin
               bus_err_o     = 1'b1;
               mw_regs_write = 1'b0;
               state_nxt     = IDLE;
            end else if (dmem_rvalid) begin
               mw_data   = me_mem2reg ? dmem_rdata : me_alu_o;
               state_nxt = IDLE;
            end else begin
               mem_stall     = 1'b1;
               mw_regs_write = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Reset must silence the bus and write-back without waiting for a clock.
      if (rst) begin
         state_nxt     = IDLE;
         launch        = 1'b0;
         dmem_req      = 1'b0;
         dmem_we       = 1'b0;
         dmem_addr     = '0;
         dmem_wdata    = '0;
         mw_regs_write = 1'b0;
         mem_stall     = 1'b0;
         misalign_o    = 1'b0;
         bus_err_o     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_we    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt == state && state != IDLE) cnt <= cnt + 1'b1;
         else                                       cnt <= '0;
         if (launch) begin
            cap_addr  <= me_alu_o;
            cap_wdata <= store_data;
            cap_we    <= me_mem_write;
         end
      end
   end

endmodule
